// File: rtl/agc_ema_ctrl.sv
// agc_ema_ctrl: sequencer that feeds an external EMA filter for an AGC loop.
// Holds one pending detector sample and strobes it into the filter no
// faster than once every MIN_GAP clocks. The coefficient is the acquisition
// coefficient while acquiring, and attack/release while tracking (chosen by
// comparing the sample with the current filter level).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   enable, restart, freeze     control (level / pulse / level)
//   coeff_acq/attack/release    coefficients, BWIDTH each
//   sample_in, sample_valid     detector magnitude and its qualifier
//   ema_out, ema_valid_out      filter accumulator feedback and stage-2 valid
//   ema_data, ema_coeff         sample and coefficient presented to the filter
//   ema_valid                   one-cycle filter strobe
//   state                       00 IDLE, 01 ACQ, 10 TRACK, 11 FREEZE
//   settled                     high in TRACK/FREEZE
//   drop_cnt                    saturating count of overwritten samples
module agc_ema_ctrl #(
  parameter int unsigned DWIDTH   = 27,
  parameter int unsigned BWIDTH   = 13,
  parameter int unsigned OUTWIDTH = 48,
  parameter int unsigned ACQ_LEN  = 64,
  parameter int unsigned MIN_GAP  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                restart,
  input  logic                freeze,
  input  logic [BWIDTH-1:0]   coeff_acq,
  input  logic [BWIDTH-1:0]   coeff_attack,
  input  logic [BWIDTH-1:0]   coeff_release,
  input  logic [DWIDTH-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic [OUTWIDTH-1:0] ema_out,
  input  logic                ema_valid_out,
  output logic [DWIDTH-1:0]   ema_data,
  output logic [BWIDTH-1:0]   ema_coeff,
  output logic                ema_valid,
  output logic [1:0]          state,
  output logic                settled,
  output logic [15:0]         drop_cnt
);

  localparam int unsigned LVL_LSB = 14;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned ACQ_W   = 16;
  localparam int unsigned DROP_W  = 16;
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP - 1);
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(ACQ_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACQ    = 2'b01,
    S_TRACK  = 2'b10,
    S_FREEZE = 2'b11
  } state_t;

  state_t              st_q, st_d;
  logic [ACQ_W-1:0]    acq_q, acq_d;
  logic                pend_q, pend_d;
  logic [DWIDTH-1:0]   pdata_q, pdata_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [DROP_W-1:0]   drop_d;
  logic [DWIDTH-1:0]   data_d;
  logic [BWIDTH-1:0]   coeff_d;
  logic [DWIDTH-1:0]   level_q, level_d;
  logic                lvl_vld_q;
  logic                issue;
  logic                load;

  // Fractional bits below the level's LSB are never needed.
  logic unused_ema_frac;
  assign unused_ema_frac = ^ema_out[LVL_LSB-1:0];

  assign state = st_q;

  // Next-state, strobe and bookkeeping logic.
  always_comb begin
    st_d    = st_q;
    acq_d   = acq_q;
    pend_d  = pend_q;
    pdata_d = pdata_q;
    gap_d   = gap_q;
    drop_d  = drop_cnt;
    data_d  = ema_data;
    coeff_d = ema_coeff;
    level_d = level_q;
    issue   = pend_q && ((st_q == S_ACQ) || (st_q == S_TRACK)) && (gap_q >= GAP_MAX);
    load    = sample_valid && enable && (st_q != S_IDLE);

    // Strobe: present the pending sample and restart the spacing counter.
    if (issue) begin
      gap_d  = '0;
      data_d = pdata_q;
      if (st_q == S_ACQ) begin
        coeff_d = coeff_acq;
      end else if (pdata_q > level_q) begin
        coeff_d = coeff_attack;
      end else begin
        coeff_d = coeff_release;
      end
    end else if (gap_q < GAP_MAX) begin
      gap_d = gap_q + GAP_W'(1);
    end

    // Pending slot: a load in the issuing cycle replaces the value being
    // issued, so it is not an overwrite.
    if (!enable) begin
      pend_d = 1'b0;
    end else if (load) begin
      pend_d  = 1'b1;
      pdata_d = sample_in;
      if (pend_q && !issue && (drop_cnt != '1)) begin
        drop_d = drop_cnt + DROP_W'(1);
      end
    end else if (issue) begin
      pend_d = 1'b0;
    end

    // Accumulator is updated the edge after stage-2 valid; sample it then.
    if (lvl_vld_q) begin
      level_d = DWIDTH'(ema_out[OUTWIDTH-1:LVL_LSB]);
    end

    if (!enable) begin
      st_d = S_IDLE;
    end else if (restart) begin
      st_d  = S_ACQ;
      acq_d = '0;
    end else begin
      case (st_q)
        S_IDLE: begin
          st_d  = S_ACQ;
          acq_d = '0;
        end
        S_ACQ: begin
          if (issue) begin
            acq_d = acq_q + ACQ_W'(1);
            if (acq_q == ACQ_LAST) begin
              st_d = S_TRACK;
            end
          end
        end
        S_TRACK: begin
          if (freeze) begin
            st_d = S_FREEZE;
          end
        end
        S_FREEZE: begin
          if (!freeze) begin
            st_d = S_TRACK;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      acq_q     <= '0;
      pend_q    <= 1'b0;
      pdata_q   <= '0;
      gap_q     <= GAP_MAX;
      drop_cnt  <= '0;
      ema_valid <= 1'b0;
      ema_data  <= '0;
      ema_coeff <= '0;
      settled   <= 1'b0;
      level_q   <= '0;
      lvl_vld_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      acq_q     <= acq_d;
      pend_q    <= pend_d;
      pdata_q   <= pdata_d;
      gap_q     <= gap_d;
      drop_cnt  <= drop_d;
      ema_valid <= issue;
      ema_data  <= data_d;
      ema_coeff <= coeff_d;
      settled   <= (st_d == S_TRACK) || (st_d == S_FREEZE);
      level_q   <= level_d;
      lvl_vld_q <= ema_valid_out;
    end
  end

endmodule

// File: doc/agc_ema_ctrl.md
AGC_EMA_CTRL -- requirements
Module: agc_ema_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, 27, sample / EMA data width, unsigned Q(27,18).
REQ-002 SHALL have parameter BWIDTH, 13, coefficient width, unsigned, 14 fractional bits implied.
REQ-003 SHALL have parameter OUTWIDTH, 48, EMA accumulator width, signed, 32 fractional bits.
REQ-004 SHALL have parameter ACQ_LEN, 64, number of acquisition strobes before tracking (range 1..65535).
REQ-005 SHALL have parameter MIN_GAP, 4, minimum clock spacing between EMA strobes (range 4..255).
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  level; 0 forces IDLE.
REQ-009 SHALL have port restart  input  1  single-cycle pulse; re-enters ACQ.
REQ-010 SHALL have port freeze  input  1  level; suspends strobes while tracking.
REQ-011 SHALL have port coeff_acq / coeff_attack / coeff_release  input  BWIDTH each  configuration coefficients.
REQ-012 SHALL have port sample_in  input  DWIDTH  detector magnitude.
REQ-013 SHALL have port sample_valid  input  1  sample_in qualifier.
REQ-014 SHALL have port ema_out  input  OUTWIDTH  filter accumulator feedback.
REQ-015 SHALL have port ema_valid_out  input  1  filter stage-2 valid; accumulator updates on the following edge.
REQ-016 SHALL have port ema_data  output  DWIDTH  sample to filter.
REQ-017 SHALL have port ema_coeff  output  BWIDTH  coefficient to filter.
REQ-018 SHALL have port ema_valid  output  1  one-cycle filter strobe.
REQ-019 SHALL have port state  output  2  00 IDLE, 01 ACQ, 10 TRACK, 11 FREEZE.
REQ-020 SHALL have port settled  output  1  high in TRACK/FREEZE.
REQ-021 SHALL have port drop_cnt  output  16  overwritten-sample count, saturating.

Function
REQ-022 SHALL hold one pending sample register; sample_valid loads it, and loading while already pending increments drop_cnt (saturating at 0xFFFF).
REQ-023 SHALL issue a strobe (ema_valid=1 for one cycle, ema_data=pending sample) when pending is set, state is ACQ or TRACK, and gap counter >= MIN_GAP-1; pending clears the same edge.
REQ-024 SHALL, when sample_valid coincides with the issuing cycle, issue the old pending value and load the new one as pending, without counting a drop.
REQ-025 SHALL reset the gap counter to 0 on each strobe and increment it, saturating at MIN_GAP-1, otherwise.
REQ-026 SHALL change ema_data and ema_coeff only on a strobe edge; both remain stable until the next strobe.
REQ-027 SHALL capture level = ema_out[OUTWIDTH-1:14] truncated to DWIDTH LSBs, one cycle after ema_valid_out is high.
REQ-028 SHALL select ema_coeff = coeff_acq in ACQ; in TRACK, coeff_attack if issued sample > level (unsigned), else coeff_release.
REQ-029 SHALL transition IDLE->ACQ when enable=1, clearing the acquisition counter.
REQ-030 SHALL count strobes in ACQ and move ACQ->TRACK on the edge of the ACQ_LEN-th strobe.
REQ-031 SHALL move TRACK->FREEZE when freeze=1 and FREEZE->TRACK when freeze=0; in FREEZE, samples still load pending but no strobe issues.
REQ-032 SHALL, on restart=1 with enable=1, enter ACQ from any state, clearing the acquisition counter (pending is kept).
REQ-033 SHALL, on enable=0, enter IDLE from any state and clear pending; enable=0 has priority over restart, and restart over freeze.
REQ-034 SHALL drop samples arriving in IDLE without counting them.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, set state=IDLE, ema_valid=0, ema_data=0, ema_coeff=0, settled=0, drop_cnt=0, level=0, pending cleared, acquisition counter=0, and gap counter=MIN_GAP-1.
REQ-036 SHALL give rst priority over all other inputs, including mid-strobe and mid-ACQ.

Verification
REQ-037 SHALL be tested: enable=1, ACQ_LEN=4, one sample every 8 clocks -> 4 strobes with coeff_acq, then state=10, settled=1.
REQ-038 SHALL be tested: sample_valid every clock for 12 clocks, MIN_GAP=4 -> strobes 4 clocks apart, 3 strobes, drop_cnt=8 (first sample issues immediately).
REQ-039 SHALL be tested: TRACK, level=0x100 (ema_out=0x100<<14), sample 0x200 -> coeff_attack; sample 0x080 -> coeff_release; sample 0x100 -> coeff_release.
REQ-040 SHALL be tested: freeze=1 for 20 clocks with samples -> no ema_valid, state=11; freeze=0 -> pending issued within MIN_GAP clocks.
REQ-041 SHALL be tested: restart and enable=0 in the same cycle -> IDLE; later restart alone in TRACK -> ACQ, coeff_acq used.
REQ-042 SHALL be tested: rst asserted during ACQ with pending set -> next cycle all outputs at REQ-035 values, no strobe.
